// File: rtl/range_session_arbiter_if.sv
// Requester and range-engine signal bundle for range_session_arbiter.
// slave = arbiter side, master = requesters/engine side.
interface range_session_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 10
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    smp_valid;
  logic [NUM_REQ-1:0]    smp_last;
  logic [NUM_REQ*DW-1:0] smp_data;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic                  eng_go;
  logic                  eng_finish;
  logic [DW-1:0]         eng_data;
  logic [DW-1:0]         eng_range;
  logic                  rsp_valid;
  logic [OW-1:0]         rsp_owner;
  logic [DW-1:0]         rsp_range;
  logic                  rsp_abort;

  modport slave (
    input  req, smp_valid, smp_last, smp_data, eng_range,
    output grant, busy, eng_go, eng_finish, eng_data,
    output rsp_valid, rsp_owner, rsp_range, rsp_abort
  );

  modport master (
    output req, smp_valid, smp_last, smp_data, eng_range,
    input  grant, busy, eng_go, eng_finish, eng_data,
    input  rsp_valid, rsp_owner, rsp_range, rsp_abort
  );
endinterface

// File: rtl/range_session_arbiter.sv
// Round-robin session arbiter for the shared min/max range engine.
// Optional stream idle timeout: define RANGE_ARB_TIMEOUT_EN.
module range_session_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int DW          = 10,
  parameter int MAX_SAMPLES = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clock,
  input  logic reset_n,
  range_session_arbiter_if.slave bus
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_SAMPLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_FINISH, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, rr_q, pick, rr_nxt;
  logic [OW:0]     sum;
  logic            found;
  logic [CW-1:0]   cnt_q;
  logic            abort_q, abort_d;
  logic [DW-1:0]   data_q, range_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [DW-1:0]   lane [NUM_REQ];
  logic            own_vld, own_last, own_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = bus.smp_data[g*DW +: DW];
  end

  assign own_vld  = bus.smp_valid[owner_q];
  assign own_last = bus.smp_last[owner_q];
  assign own_req  = bus.req[owner_q];
  assign rr_nxt   = (owner_q == OW'(NUM_REQ - 1)) ?
                    '0 : owner_q + 1'b1;

`ifdef RANGE_ARB_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       tmo_hit;
  assign tmo_hit = !own_vld && (tmo_q == 8'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
`endif

  // First asserted request at or after the rr pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_q} + (OW+1)'(i);
      if (sum >= (OW+1)'(NUM_REQ))
        sum = sum - (OW+1)'(NUM_REQ);
      if (!found && bus.req[sum[OW-1:0]]) begin
        found = 1'b1;
        pick  = sum[OW-1:0];
      end
    end
  end

  // Session state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and session end/abort decision.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE:   if (found) state_d = S_START;
      S_START: begin
        state_d = S_STREAM;
        abort_d = 1'b0;
      end
      S_STREAM: begin
        if (own_vld && (own_last ||
            cnt_q == CW'(MAX_SAMPLES - 1))) begin
          state_d = S_FINISH;
          abort_d = 1'b0;
        end else if (!own_req) begin
          state_d = S_FINISH;
          abort_d = 1'b1;
        end
`ifdef RANGE_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = S_FINISH;
          abort_d = 1'b1;
        end
`endif
      end
      S_FINISH: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Owner, grant, sample forwarding, result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      data_q  <= '0;
      range_q <= '0;
      grant_q <= '0;
    end else begin
      abort_q <= abort_d;
      if (state_q == S_IDLE && found) begin
        owner_q <= pick;
        grant_q <= NUM_REQ'(1) << pick;
      end
      if (state_q == S_START) cnt_q <= '0;
      if (state_q == S_STREAM && own_vld) begin
        data_q <= lane[owner_q];
        cnt_q  <= cnt_q + 1'b1;
      end
      if (state_q == S_FINISH)
        range_q <= abort_q ? '0 : bus.eng_range;
      if (state_q == S_RESP) begin
        rr_q    <= rr_nxt;
        grant_q <= '0;
      end
    end
  end

`ifdef RANGE_ARB_TIMEOUT_EN
  // Idle-stream counter, restarted by every owner sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                tmo_q <= '0;
    else if (state_q == S_START) tmo_q <= '0;
    else if (state_q == S_STREAM)
      tmo_q <= own_vld ? 8'd0 : tmo_q + 8'd1;
  end
`endif

  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.eng_go     = (state_q == S_START);
  assign bus.eng_finish = (state_q == S_FINISH);
  assign bus.eng_data   = data_q;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_owner  = bus.rsp_valid ? owner_q : '0;
  assign bus.rsp_range  = range_q;
  assign bus.rsp_abort  = bus.rsp_valid & abort_q;
endmodule
